input_filter: RTL and testbench
===============================

Name: input_filter

Overview:
- Parametrised, multi-channel successor to the single-bit input latch.
- Each asynchronous input bit (encoder phase, index, switch) passes through a configurable synchroniser chain, then a per-channel digital glitch filter.
- Produces filtered levels plus one-cycle rise/fall strobes.
- Sits between the chip pins and the counter/decoder logic, so every downstream path sees one coherent registered value per channel.

Parameters:
- WIDTH, 2: number of independent channels.
- SYNC_STAGES, 2: synchroniser flops per channel; legal range 1..4.
- FILTER_LEN, 3: consecutive cycles a new synchronised level must persist before it is accepted; legal range 1..16.
- RESET_VALUE, 0 (WIDTH bits): reset value of the synchroniser stages and of q_out.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- q_in  input  WIDTH  raw asynchronous inputs.
- filter_en  input  1  1 = glitch filter active; 0 = bypass filter (behaves as FILTER_LEN=1). Must be synchronous to clk.
- q_out  output  WIDTH  filtered level per channel.
- rise  output  WIDTH  one-cycle pulse when q_out[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse when q_out[i] goes 1->0.

Behaviour:
- Reset (rst low, asynchronous, at any time including mid-filter):
  - All sync stages and q_out = RESET_VALUE.
  - All counters = 0.
  - rise = fall = 0.
  - Any pending transition is discarded.
- Synchroniser: stage 1 samples q_in[i]; each stage k copies stage k-1. The value used downstream (sync[i]) is the last stage only. No combinational path from q_in to any output.
- Filter, per channel:
  - Counter width is ceil(log2(FILTER_LEN)), minimum 1 bit.
  - When sync[i] == q_out[i]: cnt <= 0.
  - When sync[i] != q_out[i] and cnt == FILTER_LEN-1: q_out[i] <= sync[i] and cnt <= 0.
  - When sync[i] != q_out[i] otherwise: cnt <= cnt+1.
  - A mismatch shorter than FILTER_LEN cycles at sync[i] is rejected; the counter restarts from 0 on any return to agreement.
- Bypass: when filter_en = 0, the effective length is 1 and cnt is held at 0. Toggling filter_en mid-count clears cnt; q_out never glitches as a result.
- Latency: q_in[i] changes and stays stable from before edge E1. q_out[i] updates on edge E1 + SYNC_STAGES + FILTER_LEN - 1, i.e. SYNC_STAGES+FILTER_LEN edges including E1. Defaults: 5 edges; bypass: SYNC_STAGES+1 = 3 edges.
- Strobes:
  - rise[i] and fall[i] are registered and asserted on the same edge that q_out[i] changes.
  - Each lasts exactly one cycle and is cleared on the following edge unless q_out toggles again.
  - rise[i] and fall[i] are never both 1.
  - A toggle every cycle is only possible with FILTER_LEN=1; the strobes then alternate on consecutive cycles.
- Channels are fully independent; simultaneous transitions on several channels are each processed with identical latency.
- All outputs come directly from flip-flops, so any two consumers of q_out[i] (or of its complement) always agree on a given edge.

Test Plan:
- Reset value: RESET_VALUE=2'b10, rst low then high with q_in=2'b10 held -> q_out=2'b10, rise=fall=0, no strobes for 20 cycles.
- Nominal latency: defaults, q_in[0] 0->1 stable before edge E1 -> q_out[0]=1 and rise[0]=1 on edge E1+4 only; rise[0]=0 on E1+5; q_out[1] unchanged.
- Glitch rejection: defaults, q_in[0] high for exactly 2 cycles then low -> q_out[0] stays 0, no strobe. A 3-cycle pulse -> q_out[0] high for 3 cycles, then one rise and one fall pulse.
- Bypass: filter_en=0, q_in[1] 1->0 -> q_out[1]=0 and fall[1]=1 after 3 edges. A 1-cycle pulse on q_in[1] is passed through as a 1-cycle q_out pulse.
- Reset mid-operation: defaults, q_in[0] rises, rst asserted low 2 edges later for 1 cycle -> q_out[0]=0 and counter cleared immediately. After release, q_out[0] rises exactly 5 edges after the first edge following release, not earlier.
- Async sampling sweep: WIDTH=2, q_in[0] toggled every 11 ns with 10 ns clk, q_in[1] = ~q_in[0] -> q_out[1] == ~q_out[0] at every edge; rise[0] coincides with fall[1] throughout.

Source files
------------

// File: rtl/input_filter.sv
`timescale 1ns/100ps
// input_filter: per-channel synchroniser chain followed by a digital glitch
// filter. Produces a registered filtered level plus one-cycle rise/fall
// strobes for every channel.
module input_filter #(
  parameter int               WIDTH       = 2,
  parameter int               SYNC_STAGES = 2,   // 1..4
  parameter int               FILTER_LEN  = 3,   // 1..16
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active low
  input  logic [WIDTH-1:0] q_in,
  input  logic             filter_en,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int               CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] q_d;

  // Synchroniser chain: stage 0 samples the pins, each later stage copies the previous one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: these arrays are a handful of flops, not RAM, so they are reset
      // like any other register; a real memory would be left unreset.
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_VALUE;
    end else begin
      // NOTE: non-blocking assignments make every stage read its neighbour's
      // old value, which is what turns this loop into a shift chain.
      sync_q[0] <= q_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Only the last stage is considered settled enough to feed the filter.
  assign sync = sync_q[SYNC_STAGES-1];

  // Filter decision per channel: accept a disagreement once it has persisted
  // for the full filter length (or immediately in bypass), else count it.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    q_d = q_out;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != q_out[i]) begin
        if (!filter_en || cnt_q[i] == CNT_LAST) begin
          q_d[i] = sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Filter state, accepted level and edge strobes, all straight from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_out <= RESET_VALUE;
      rise  <= '0;
      fall  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      q_out <= q_d;
      rise  <= q_d & ~q_out;
      fall  <= ~q_d & q_out;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_input_filter.sv
`timescale 1ns/100ps
// tb_input_filter: directed scenarios plus randomized stimulus, checked every
// cycle against a history-window model of the synchroniser and filter.
module tb_input_filter;

  localparam int         W  = 2;
  localparam int         S  = 2;
  localparam int         L  = 3;
  localparam logic [1:0] RV = 2'b10;

  logic       clk;
  logic       rst;
  logic [1:0] q_in;
  logic       filter_en;
  logic [1:0] q_out;
  logic [1:0] rise;
  logic [1:0] fall;

  int n_cmp = 0;
  int n_bad = 0;

  input_filter #(
    .WIDTH(W), .SYNC_STAGES(S), .FILTER_LEN(L), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .filter_en(filter_en),
    .q_out(q_out), .rise(rise), .fall(fall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pipe holds the raw samples still travelling through the synchroniser;
  // hist[i] bit k records whether edge (now-1-k) was an enabled edge on which
  // channel i disagreed and did not yet switch.
  logic [1:0]   pipe [$];
  logic [L-2:0] hist [W];
  logic [1:0]   m_q, m_rise, m_fall;

  task automatic model_reset();
    pipe.delete();
    for (int k = 0; k < S; k++) pipe.push_back(RV);
    for (int i = 0; i < W; i++) hist[i] = '0;
    m_q    = RV;
    m_rise = '0;
    m_fall = '0;
  endtask

  task automatic model_step();
    logic [1:0] sp;
    logic       full, upd, counted;
    sp = pipe.pop_front();
    pipe.push_back(q_in);
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < W; i++) begin
      full    = &hist[i];
      upd     = (sp[i] != m_q[i]) && (!filter_en || full);
      counted = filter_en && (sp[i] != m_q[i]) && !upd;
      hist[i] = (hist[i] << 1) | {{(L-2){1'b0}}, counted};
      if (upd) begin
        m_q[i]    = sp[i];
        m_rise[i] = sp[i];
        m_fall[i] = ~sp[i];
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("model_q_out", 32'(q_out), 32'(m_q));
      check("model_rise",  32'(rise),  32'(m_rise));
      check("model_fall",  32'(fall),  32'(m_fall));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // Toggle q_in[0] every 11 ns with q_in[1] its complement, checking invariants.
  task automatic sweep(input int ncycles);
    fork
      begin
        #0.5;
        repeat ((ncycles * 10 - 4) / 11) begin
          q_in = {q_in[0], ~q_in[0]};
          #11;
        end
      end
      begin
        repeat (ncycles) begin
          @(negedge clk);
          check("sweep_q_compl",   32'(q_out[1] ^ q_out[0]), 1);
          check("sweep_rise_fall", 32'(rise[0] ^ fall[1]),   0);
        end
      end
    join
  endtask

  initial begin
    int hi_cnt, r_cnt, f_cnt;
    rst       = 1'b0;
    q_in      = 2'b10;
    filter_en = 1'b1;

    // Reset value held with matching inputs: no movement for 20 cycles.
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("reset_q_out", 32'(q_out), 32'(2'b10));
      check("reset_rise",  32'(rise),  0);
      check("reset_fall",  32'(fall),  0);
    end

    // Nominal latency: change ahead of E1, accepted on E1+4.
    q_in[0] = 1'b1;
    @(posedge clk);
    for (int e = 0; e <= 5; e++) begin
      @(negedge clk);
      check("nom_q0",    32'(q_out[0]), 32'(e >= 4));
      check("nom_rise0", 32'(rise[0]),  32'(e == 4));
      check("nom_q1",    32'(q_out[1]), 1);
    end

    // Glitch rejection: 2-cycle pulse dropped, 3-cycle pulse passed.
    q_in[0] = 1'b0;
    repeat (8) @(negedge clk);
    q_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    q_in[0] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("glitch2_q0",    32'(q_out[0]), 0);
      check("glitch2_rise0", 32'(rise[0]),  0);
    end
    hi_cnt = 0; r_cnt = 0; f_cnt = 0;
    q_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    q_in[0] = 1'b0;
    repeat (12) begin
      @(negedge clk);
      hi_cnt += int'(q_out[0]);
      r_cnt  += int'(rise[0]);
      f_cnt  += int'(fall[0]);
    end
    check("pulse3_high_cycles", hi_cnt, 3);
    check("pulse3_rises",       r_cnt,  1);
    check("pulse3_falls",       f_cnt,  1);

    // Bypass: 3-edge latency, 1-cycle pulse passes through as 1 cycle.
    filter_en = 1'b0;
    repeat (3) @(negedge clk);
    q_in[1] = 1'b0;
    @(posedge clk);
    for (int e = 0; e <= 3; e++) begin
      @(negedge clk);
      check("byp_q1",    32'(q_out[1]), 32'(e < 2));
      check("byp_fall1", 32'(fall[1]),  32'(e == 2));
    end
    hi_cnt = 0; r_cnt = 0;
    q_in[1] = 1'b1;
    @(negedge clk);
    q_in[1] = 1'b0;
    repeat (8) begin
      @(negedge clk);
      hi_cnt += int'(q_out[1]);
      r_cnt  += int'(rise[1]);
    end
    check("byp_pulse_high_cycles", hi_cnt, 1);
    check("byp_pulse_rises",       r_cnt,  1);

    // Reset in the middle of a pending transition.
    filter_en = 1'b1;
    q_in      = 2'b00;
    repeat (8) @(negedge clk);
    q_in[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_q_out", 32'(q_out), 32'(RV));
    check("midrst_rise",  32'(rise),  0);
    check("midrst_fall",  32'(fall),  0);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    for (int e = 0; e <= 5; e++) begin
      @(negedge clk);
      check("midrst_q0",    32'(q_out[0]), 32'(e >= 4));
      check("midrst_rise0", 32'(rise[0]),  32'(e == 4));
    end

    // Asynchronous sampling sweep, filtered then bypassed.
    q_in = 2'b10;
    repeat (10) @(negedge clk);
    sweep(40);
    filter_en = 1'b0;
    @(negedge clk);
    sweep(40);

    // Randomized traffic with occasional bypass toggling.
    filter_en = 1'b1;
    repeat (400) begin
      @(negedge clk);
      for (int i = 0; i < W; i++)
        if ($urandom_range(3) == 0) q_in[i] = ~q_in[i];
      if ($urandom_range(24) == 0) filter_en = ~filter_en;
    end
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
